// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: prioritised redirect selection, stall-time redirect
// holding, delay-slot tagging and misaligned-fetch flagging.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        branchD,
  input  logic        takenD,
  input  logic        jumpD,
  input  logic        jrD,
  input  logic [31:0] pc_plus4D,
  input  logic [31:0] imm_extD,
  input  logic [25:0] instr_indexD,
  input  logic [31:0] rs_valD,
  input  logic        flush_excM,
  input  logic [31:0] exc_pcM,
  output logic [31:0] pcF,
  output logic [31:0] pc_plus4F,
  output logic        inst_sram_en,
  output logic        is_in_delayslotF,
  output logic        adelF
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      state, state_n;
  logic [31:0] pend_pc, pend_pc_n;
  logic [31:0] pc_n;
  logic        flush_tag;

  logic        redir;
  logic [31:0] target;

  // Non-exception redirect; the exception path is handled separately because
  // it bypasses both the stall and the pending register.
  always_comb begin
    redir  = 1'b0;
    target = 32'd0;
    if (jrD) begin
      redir  = 1'b1;
      target = rs_valD;
    end else if (jumpD) begin
      redir  = 1'b1;
      target = {pc_plus4D[31:28], instr_indexD, 2'b00};
    end else if (branchD && takenD) begin
      redir  = 1'b1;
      target = pc_plus4D + (imm_extD << 2);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_n   = state;
    pc_n      = pcF;
    pend_pc_n = pend_pc;
    if (flush_excM) begin
      pc_n    = exc_pcM;
      state_n = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (redir) begin
            if (stallF) begin
              pend_pc_n = target;
              state_n   = PEND;
            end else begin
              pc_n = target;
            end
          end else if (!stallF) begin
            pc_n = pcF + 32'd4;
          end
        end
        PEND: begin
          // Redirects seen here belong to the stream we are already redirecting.
          if (!stallF) begin
            pc_n    = pend_pc;
            state_n = RUN;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state        <= RUN;
      pcF          <= RESET_PC;
      pend_pc      <= 32'd0;
      inst_sram_en <= 1'b0;
      flush_tag    <= 1'b0;
    end else begin
      state        <= state_n;
      pcF          <= pc_n;
      pend_pc      <= pend_pc_n;
      inst_sram_en <= 1'b1;
      flush_tag    <= flush_excM;
    end
  end

  assign pc_plus4F        = pcF + 32'd4;
  assign adelF            = |pcF[1:0];
  assign is_in_delayslotF = (branchD | jumpD | jrD) & ~flush_tag;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed and randomized bench for pc_fetch_ctrl against a queue-based model
// of the fetch stream.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst, stallF, branchD, takenD, jumpD, jrD, flush_excM;
  logic [31:0] pc_plus4D, imm_extD, rs_valD, exc_pcM;
  logic [25:0] instr_indexD;
  logic [31:0] pcF, pc_plus4F;
  logic        inst_sram_en, is_in_delayslotF, adelF;

  int checks = 0;
  int errors = 0;

  // Model: current fetch PC, redirect waiting for the stall to release, and
  // whether the previous edge took an exception.
  logic [31:0] m_pc;
  logic [31:0] m_pending[$];
  logic        m_sram, m_after_exc;

  pc_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .branchD(branchD), .takenD(takenD),
    .jumpD(jumpD), .jrD(jrD), .pc_plus4D(pc_plus4D), .imm_extD(imm_extD),
    .instr_indexD(instr_indexD), .rs_valD(rs_valD), .flush_excM(flush_excM),
    .exc_pcM(exc_pcM), .pcF(pcF), .pc_plus4F(pc_plus4F),
    .inst_sram_en(inst_sram_en), .is_in_delayslotF(is_in_delayslotF), .adelF(adelF)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; stallF = 0; branchD = 0; takenD = 0; jumpD = 0; jrD = 0;
    flush_excM = 0; pc_plus4D = 0; imm_extD = 0; instr_indexD = 0;
    rs_valD = 0; exc_pcM = 0;
  endtask

  // Decode's requested target from the priority rules, or none.
  task automatic decode_target(output bit valid, output logic [31:0] t);
    valid = 1; t = 0;
    if (jrD) t = rs_valD;
    else if (jumpD) t = {pc_plus4D[31:28], instr_indexD, 2'b00};
    else if (branchD && takenD) t = pc_plus4D + imm_extD * 4;
    else valid = 0;
  endtask

  task automatic model_edge();
    bit          v;
    logic [31:0] t;
    if (rst) begin
      m_pc = RESET_PC; m_pending.delete(); m_sram = 0; m_after_exc = 0;
      return;
    end
    m_sram = 1;
    m_after_exc = flush_excM;
    decode_target(v, t);
    if (flush_excM) begin
      m_pc = exc_pcM;
      m_pending.delete();
    end else if (m_pending.size() != 0) begin
      if (!stallF) m_pc = m_pending.pop_front();
    end else if (v) begin
      if (stallF) m_pending.push_back(t);
      else m_pc = t;
    end else if (!stallF) begin
      m_pc = m_pc + 4;
    end
  endtask

  // Check outputs mid-cycle against the model, then advance one edge.
  task automatic tick();
    @(negedge clk);
    check("pcF", pcF, m_pc);
    check("pc_plus4F", pc_plus4F, m_pc + 32'd4);
    check("adelF", adelF, (m_pc[1:0] != 2'b00));
    check("inst_sram_en", inst_sram_en, m_sram);
    check("is_in_delayslotF", is_in_delayslotF, (branchD | jumpD | jrD) & ~m_after_exc);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); model_edge(); #1;

    // Reset state, then free-running sequential fetch.
    check("reset_pc", pcF, RESET_PC);
    check("reset_sram_en", inst_sram_en, 1'b0);
    rst = 0;
    tick(); check("seq1", pcF, 32'hBFC00004); check("sram_on", inst_sram_en, 1'b1);
    tick(); check("seq2", pcF, 32'hBFC00008);
    tick(); check("seq3", pcF, 32'hBFC0000C);

    // Taken branch with negative offset, then not-taken.
    branchD = 1; takenD = 1; pc_plus4D = 32'hBFC00010; imm_extD = 32'hFFFFFFFE;
    tick(); check("branch_taken", pcF, 32'hBFC00008);
    takenD = 0;
    tick(); check("branch_not_taken", pcF, 32'hBFC0000C);

    // Jump, then jr colliding with jump.
    idle(); jumpD = 1; pc_plus4D = 32'hBFC00020; instr_indexD = 26'h0000100;
    tick(); check("jump", pcF, 32'hB0000400);
    jrD = 1; rs_valD = 32'h80001000;
    tick(); check("jr_over_jump", pcF, 32'h80001000);

    // Taken branch under a 3-cycle stall, released with a stray jump present.
    idle(); branchD = 1; takenD = 1; pc_plus4D = 32'h80001010; imm_extD = 32'h00000010;
    stallF = 1;
    repeat (3) tick();
    check("pend_hold", pcF, 32'h80001000);
    idle(); jumpD = 1; pc_plus4D = 32'h80002000; instr_indexD = 26'h0000040;
    tick(); check("pend_release", pcF, 32'h80001050);
    idle();
    tick(); check("after_release", pcF, 32'h80001054);

    // Exception while pending and stalled.
    branchD = 1; takenD = 1; pc_plus4D = 32'h80001058; imm_extD = 32'h00000004; stallF = 1;
    tick(); check("pend_enter", pcF, 32'h80001054);
    flush_excM = 1; exc_pcM = 32'hBFC00380;
    tick(); check("exc_in_pend", pcF, 32'hBFC00380);
    idle();
    tick(); check("exc_next_free", pcF, 32'hBFC00384);

    // Reset while pending, then a misaligned jr target.
    jumpD = 1; pc_plus4D = 32'h80000000; instr_indexD = 26'h0000010; stallF = 1;
    tick();
    idle(); rst = 1;
    tick(); check("rst_in_pend", pcF, RESET_PC);
    idle();
    tick(); check("post_rst_run", pcF, 32'hBFC00004);
    jrD = 1; rs_valD = 32'h80000002;
    tick(); check("adel_pc", pcF, 32'h80000002); check("adel_flag", adelF, 1'b1);

    // PC wrap at the top of the address space.
    idle(); jrD = 1; rs_valD = 32'hFFFFFFFC;
    tick();
    idle();
    tick(); check("wrap", pcF, 32'h00000000);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 49) == 0);
      stallF       = ($urandom_range(0, 2) == 0);
      flush_excM   = ($urandom_range(0, 11) == 0);
      branchD      = ($urandom_range(0, 3) == 0);
      takenD       = $urandom_range(0, 1) == 1;
      jumpD        = ($urandom_range(0, 5) == 0);
      jrD          = ($urandom_range(0, 7) == 0);
      pc_plus4D    = $urandom;
      imm_extD     = {{16{1'b0}}, 16'($urandom)};
      if ($urandom_range(0, 1) == 1) imm_extD[31:16] = 16'hFFFF;
      instr_indexD = 26'($urandom);
      rs_valD      = $urandom;
      exc_pcM      = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-stage program-counter controller for the 5-stage MIPS pipeline, sitting directly downstream of the decode-stage branch comparator. It consumes the comparator's taken/not-taken result together with decode-stage jump information and exception redirects, and produces the next fetch PC. Redirects that arrive while fetch is stalled by the instruction SRAM are held in a pending register and applied when the stall releases. It also tags delay-slot instructions and flags misaligned fetch addresses.

## Interface
- RESET_PC, 32'hBFC00000, PC loaded on reset.
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stallF  input  1  fetch stall from the hazard/SRAM unit; PC holds when high.
- branchD  input  1  decode instruction is a conditional branch (beq/bne/bgtz/blez/regimm class).
- takenD  input  1  comparator result for the decode instruction; only meaningful when branchD=1.
- jumpD  input  1  decode instruction is j/jal.
- jrD  input  1  decode instruction is jr/jalr.
- pc_plus4D  input  32  PC+4 of the decode instruction.
- imm_extD  input  32  sign-extended 16-bit immediate of the decode instruction.
- instr_indexD  input  26  jump index field.
- rs_valD  input  32  forwarded rs value (jr target).
- flush_excM  input  1  exception/eret redirect from memory stage.
- exc_pcM  input  32  exception handler or EPC target.
- pcF  output  32  current fetch address (registered).
- pc_plus4F  output  32  pcF + 4, wrapping modulo 2^32.
- inst_sram_en  output  1  instruction SRAM enable.
- is_in_delayslotF  output  1  instruction currently in fetch is a delay slot.
- adelF  output  1  pcF[1:0] != 2'b00.

## Operation
- Redirect request (combinational) with strict priority: flush_excM > jrD > jumpD > (branchD & takenD) > none.
- Targets, all 32-bit, wrap modulo 2^32: exception = exc_pcM; jr = rs_valD; jump = {pc_plus4D[31:28], instr_indexD, 2'b00}; branch = pc_plus4D + (imm_extD << 2).
- branchD=1 with takenD=0 is not a redirect; takenD ignored when branchD=0.
- State machine, two states:
  - RUN: no pending redirect.
  - PEND: target latched in pend_pc, waiting for stallF to drop.
- RUN transitions:
  - flush_excM: pcF <= exc_pcM, regardless of stallF; stay RUN.
  - Other redirect with stallF=0: pcF <= target; stay RUN.
  - Other redirect with stallF=1: pend_pc <= target, go PEND; pcF holds.
  - No redirect, stallF=0: pcF <= pcF + 4. With stallF=1: hold.
- PEND transitions:
  - flush_excM: pcF <= exc_pcM, discard pend_pc, go RUN.
  - stallF=0: pcF <= pend_pc, go RUN. Any non-exception redirect in the same cycle is ignored; it belongs to the already-redirected stream.
  - stallF=1: hold pcF and pend_pc. New non-exception redirects are ignored because decode is stalled and re-presents the same one.
- is_in_delayslotF = branchD | jumpD | jrD (combinational), forced 0 in the cycle after a flush_excM redirect.
- adelF = |pcF[1:0] (combinational). The PC is not corrected; downstream exception logic handles it.
- pc_plus4F = pcF + 32'd4 (combinational).

## Timing
- Reset (rst=1 at edge): pcF=RESET_PC, state=RUN, pend_pc=0, inst_sram_en=0, flush-tag register=0. The outputs that follow are is_in_delayslotF=0 (when decode inputs are 0), adelF=0, pc_plus4F=RESET_PC+4.
- inst_sram_en is registered and goes 1 on the first edge with rst=0. It stays 1 thereafter.
- Redirect latency: redirect seen at edge N (stallF=0) gives pcF=target after edge N. A pending redirect is applied on the first edge with stallF=0.
- rst has priority over every input, including mid-PEND; the pending target is dropped.
- flush_excM with stallF=1 still updates pcF at that edge.
- pcF=32'hFFFFFFFC with no redirect and no stall wraps to 32'h00000000.

## Test plan
- Reset then 3 unstalled cycles -> pcF = BFC00000, BFC00004, BFC00008, BFC0000C; inst_sram_en 0 then 1.
- branchD=1, takenD=1, pc_plus4D=BFC00010, imm_extD=FFFFFFFE, stallF=0 -> next pcF=BFC00008, is_in_delayslotF=1 that cycle. Repeat with takenD=0 -> pcF=pcF+4.
- jumpD=1, pc_plus4D=BFC00020, instr_indexD=26'h0000100 -> pcF=B0000400. Also assert jrD=1, rs_valD=80001000 together with jumpD -> pcF=80001000 (jr wins).
- Branch taken with stallF=1 for 3 cycles -> pcF held and state PEND. stallF drops -> pcF=target on that edge. A different jump asserted on the release cycle is ignored.
- In PEND with stallF=1, flush_excM=1, exc_pcM=BFC00380 -> pcF=BFC00380 immediately, pending discarded, next free cycle pcF=BFC00384.
- rst asserted during PEND -> pcF=BFC00000, state RUN. rs_valD=80000002 via jr -> adelF=1.
